bp_resolve_queue: RTL
=====================

// Module: bp_resolve_queue
// PURPOSE
//  Resolution-side companion to the local-history predictor: records every fetch-stage
//  prediction in a small in-order queue and checks it against the actual outcome at M.
//  Drives the predictor's update port (branchM/hashed_pcM/hashed_pc2M/pcsrcM) and
//  raises a one-cycle flush with the redirect PC on a misprediction.
//  Sits between the fetch-side predictor lookup and the memory-stage branch resolution.
// PARAMETERS
//  QDEPTH_LOG2  2   log2 of queue entries (default 4 entries)
//  BHT_DEPTH    3   width of hashed PC fields, matches predictor
//  PC_W         32  PC width
//  CNT_W        32  width of statistics counters
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, synchronous, active-high
//  push_validF    in   1            fetch issued a predicted branch this cycle
//  push_hashF     in   BHT_DEPTH    BHT index of the branch
//  push_hash2F    in   BHT_DEPTH    PHT high-index of the branch
//  push_predF     in   1            predicted direction (pcsrcPF)
//  push_targetF   in   PC_W         predicted taken target
//  push_fallF     in   PC_W         fall-through PC (branch PC + 8)
//  resolve_validM in   1            oldest in-flight branch resolves this cycle
//  resolve_takenM in   1            actual direction
//  resolve_targetM in  PC_W         actual taken target
//  full           out  1            queue holds 2**QDEPTH_LOG2 entries
//  empty          out  1            queue holds 0 entries
//  occupancy      out  QDEPTH_LOG2+1 entry count
//  upd_valid      out  1            predictor update strobe (-> branchM)
//  upd_hash       out  BHT_DEPTH    -> hashed_pcM
//  upd_hash2      out  BHT_DEPTH    -> hashed_pc2M
//  upd_taken      out  1            -> pcsrcM
//  flush          out  1            squash younger wrong-path instructions
//  redirect_pc    out  PC_W         correct fetch PC, valid when flush=1
//  overflow_err   out  1            sticky: push dropped while full
//  underflow_err  out  1            sticky: resolve while empty
//  n_branch       out  CNT_W        resolved branch count, saturating
//  n_mispred      out  CNT_W        mispredict count, saturating
// BEHAVIOUR
//  - Reset: pointers/occupancy 0, empty=1, full=0; all other outputs 0; mid-op reset
//    discards every entry and pending update/flush on the same edge.
//  - Circular buffer, rd/wr pointers QDEPTH_LOG2+1 bits (MSB wrap bit); full when
//    indices equal and wrap bits differ; empty when equal.
//  - Push writes {hash,hash2,pred,target,fall} at wr_ptr. Push while full and no pop:
//    dropped, overflow_err<=1. Push+resolve same cycle while full: both accepted.
//  - Resolve compares head entry: mispredict = (pred != taken) | (taken & target != resolve_targetM).
//  - Resolve while empty: ignored (no update, no counters), underflow_err<=1.
//  - Latency: upd_*, flush, redirect_pc registered, valid the cycle after resolve;
//    upd_valid/flush are single-cycle pulses; upd_hash/hash2 from head, upd_taken = actual.
//  - Mispredict: flush<=1, redirect_pc <= taken ? resolve_targetM : head.fall; queue
//    cleared on that edge (younger entries are wrong-path); a push in the same cycle
//    is dropped without setting overflow_err. Correct prediction: pop head only.
//  - Counters: n_branch +1 per accepted resolve, n_mispred +1 per mispredict; hold at all-ones.
//  - Pointer arithmetic modulo 2**(QDEPTH_LOG2+1); occupancy = wr_ptr - rd_ptr.
// TESTING
//  - Reset then push 4 (pred=1,target=0x100) -> full=1,occupancy=4; 5th push -> overflow_err=1.
//  - Resolve taken, target 0x100 on head -> next cycle upd_valid=1,upd_taken=1,flush=0,occupancy drops by 1.
//  - Head pred=1, resolve not-taken, fall=0x208 -> flush=1,redirect_pc=0x208,empty=1,n_mispred=1.
//  - Head pred=1 target 0x100, resolve taken target 0x180 -> flush=1,redirect_pc=0x180.
//  - Resolve with empty queue -> underflow_err=1, upd_valid=0, n_branch unchanged.
//  - Full queue, push+correct resolve same cycle -> occupancy stays 4, no overflow; rst mid-run -> all outputs 0.

Source files
------------

// File: rtl/bp_resolve_queue_if.sv
// Bundles the fetch-side push port, the M-stage resolve port and the
// predictor-update/flush/status outputs of bp_resolve_queue.
interface bp_resolve_queue_if #(
  parameter int QDEPTH_LOG2 = 2,
  parameter int BHT_DEPTH   = 3,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
);
  logic                   push_validF;
  logic [BHT_DEPTH-1:0]   push_hashF;
  logic [BHT_DEPTH-1:0]   push_hash2F;
  logic                   push_predF;
  logic [PC_W-1:0]        push_targetF;
  logic [PC_W-1:0]        push_fallF;
  logic                   resolve_validM;
  logic                   resolve_takenM;
  logic [PC_W-1:0]        resolve_targetM;
  logic                   full;
  logic                   empty;
  logic [QDEPTH_LOG2:0]   occupancy;
  logic                   upd_valid;
  logic [BHT_DEPTH-1:0]   upd_hash;
  logic [BHT_DEPTH-1:0]   upd_hash2;
  logic                   upd_taken;
  logic                   flush;
  logic [PC_W-1:0]        redirect_pc;
  logic                   overflow_err;
  logic                   underflow_err;
  logic [CNT_W-1:0]       n_branch;
  logic [CNT_W-1:0]       n_mispred;

  modport slave (
    input  push_validF, push_hashF, push_hash2F, push_predF, push_targetF, push_fallF,
    input  resolve_validM, resolve_takenM, resolve_targetM,
    output full, empty, occupancy, upd_valid, upd_hash, upd_hash2, upd_taken,
    output flush, redirect_pc, overflow_err, underflow_err, n_branch, n_mispred
  );

  modport master (
    output push_validF, push_hashF, push_hash2F, push_predF, push_targetF, push_fallF,
    output resolve_validM, resolve_takenM, resolve_targetM,
    input  full, empty, occupancy, upd_valid, upd_hash, upd_hash2, upd_taken,
    input  flush, redirect_pc, overflow_err, underflow_err, n_branch, n_mispred
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of fetch-stage branch predictions; checks the oldest one against
// the M-stage outcome, drives the predictor update port and flushes on mispredict.
module bp_resolve_queue #(
  parameter int QDEPTH_LOG2 = 2,
  parameter int BHT_DEPTH   = 3,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  bp_resolve_queue_if.slave bus
);
  localparam int DEPTH = 1 << QDEPTH_LOG2;
  localparam int PTR_W = QDEPTH_LOG2 + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [BHT_DEPTH-1:0] hash_mem   [DEPTH];
  logic [BHT_DEPTH-1:0] hash2_mem  [DEPTH];
  logic                 pred_mem   [DEPTH];
  logic [PC_W-1:0]      target_mem [DEPTH];
  logic [PC_W-1:0]      fall_mem   [DEPTH];

  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [QDEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic                   is_empty, is_full;

  logic [BHT_DEPTH-1:0] head_hash, head_hash2;
  logic                 head_pred;
  logic [PC_W-1:0]      head_target, head_fall;

  logic            res_acc, mispred, pop, push_acc, push_ovf, res_unf;
  logic [PC_W-1:0] redirect_next;

  logic                 upd_valid_p1, upd_taken_p1, flush_p1;
  logic [BHT_DEPTH-1:0] upd_hash_p1, upd_hash2_p1;
  logic [PC_W-1:0]      redirect_p1;
  logic                 overflow_q, underflow_q;
  logic [CNT_W-1:0]     n_branch_q, n_mispred_q;

  always_comb begin
    wr_idx   = wr_ptr[QDEPTH_LOG2-1:0];
    rd_idx   = rd_ptr[QDEPTH_LOG2-1:0];
    is_empty = (wr_ptr == rd_ptr);
    is_full  = (wr_idx == rd_idx) && (wr_ptr[QDEPTH_LOG2] != rd_ptr[QDEPTH_LOG2]);

    head_hash   = hash_mem[rd_idx];
    head_hash2  = hash2_mem[rd_idx];
    head_pred   = pred_mem[rd_idx];
    head_target = target_mem[rd_idx];
    head_fall   = fall_mem[rd_idx];

    res_acc  = bus.resolve_validM && !is_empty;
    res_unf  = bus.resolve_validM && is_empty;
    mispred  = res_acc && ((head_pred != bus.resolve_takenM) ||
                           (bus.resolve_takenM && (head_target != bus.resolve_targetM)));
    pop      = res_acc && !mispred;
    // A push alongside a mispredict is wrong-path and silently dropped.
    push_acc = bus.push_validF && !mispred && (!is_full || pop);
    push_ovf = bus.push_validF && is_full && !res_acc;

    redirect_next = bus.resolve_takenM ? bus.resolve_targetM : head_fall;
  end

  // Entry storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push_acc) begin
      hash_mem[wr_idx]   <= bus.push_hashF;
      hash2_mem[wr_idx]  <= bus.push_hash2F;
      pred_mem[wr_idx]   <= bus.push_predF;
      target_mem[wr_idx] <= bus.push_targetF;
      fall_mem[wr_idx]   <= bus.push_fallF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (mispred) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Stage p1: registered update/flush outputs, one cycle after resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_p1 <= 1'b0;
      upd_taken_p1 <= 1'b0;
      upd_hash_p1  <= '0;
      upd_hash2_p1 <= '0;
      flush_p1     <= 1'b0;
      redirect_p1  <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      n_branch_q   <= '0;
      n_mispred_q  <= '0;
    end else begin
      upd_valid_p1 <= res_acc;
      flush_p1     <= mispred;
      if (res_acc) begin
        upd_hash_p1  <= head_hash;
        upd_hash2_p1 <= head_hash2;
        upd_taken_p1 <= bus.resolve_takenM;
        n_branch_q   <= sat_inc(n_branch_q);
      end
      if (mispred) begin
        redirect_p1 <= redirect_next;
        n_mispred_q <= sat_inc(n_mispred_q);
      end
      if (push_ovf) overflow_q  <= 1'b1;
      if (res_unf)  underflow_q <= 1'b1;
    end
  end

  assign bus.full          = is_full;
  assign bus.empty         = is_empty;
  assign bus.occupancy     = wr_ptr - rd_ptr;
  assign bus.upd_valid     = upd_valid_p1;
  assign bus.upd_hash      = upd_hash_p1;
  assign bus.upd_hash2     = upd_hash2_p1;
  assign bus.upd_taken     = upd_taken_p1;
  assign bus.flush         = flush_p1;
  assign bus.redirect_pc   = redirect_p1;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
  assign bus.n_branch      = n_branch_q;
  assign bus.n_mispred     = n_mispred_q;
endmodule
